// File: rtl/rec_sequencer.sv
// rec_sequencer: records key notes into an external memory and plays them back timed by tick pulses.
// Optional build macro REC_LOOP_EN: when defined, playback wraps to the first note instead of stopping.
`ifndef OCTAVE_BITS
`define OCTAVE_BITS 3
`endif
`ifndef NOTE_BITS
`define NOTE_BITS 4
`endif
`ifndef LENGTH_BITS
`define LENGTH_BITS 3
`endif
`ifndef FULL_NOTE_BITS
`define FULL_NOTE_BITS 2
`endif
`ifndef REC_CNT_BITS
`define REC_CNT_BITS 3
`endif

module rec_sequencer #(
    parameter int GAP_TICKS = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rec_start,
    input  logic                         play_start,
    input  logic                         stop,
    input  logic                         tick,
    input  logic                         key_valid,
    input  logic [`OCTAVE_BITS-1:0]      octave,
    input  logic [`NOTE_BITS-1:0]        note,
    input  logic [`LENGTH_BITS-1:0]      length,
    input  logic [`FULL_NOTE_BITS-1:0]   full_note,
    output logic                         mem_rw,
    output logic                         mem_en,
    output logic [`REC_CNT_BITS-1:0]     mem_cnt,
    output logic [`OCTAVE_BITS-1:0]      mem_octave,
    output logic [`NOTE_BITS-1:0]        mem_note,
    output logic [`LENGTH_BITS-1:0]      mem_length,
    output logic [`FULL_NOTE_BITS-1:0]   mem_full_note,
    input  logic [`OCTAVE_BITS-1:0]      octave_r,
    input  logic [`NOTE_BITS-1:0]        note_r,
    input  logic [`LENGTH_BITS-1:0]      length_r,
    input  logic [`FULL_NOTE_BITS-1:0]   full_note_r,
    output logic                         play_valid,
    output logic [`OCTAVE_BITS-1:0]      play_octave,
    output logic [`NOTE_BITS-1:0]        play_note,
    output logic [`FULL_NOTE_BITS-1:0]   play_full_note,
    output logic [`REC_CNT_BITS-1:0]     play_idx,
    output logic [`REC_CNT_BITS:0]       rec_count,
    output logic                         full,
    output logic                         busy_rec,
    output logic                         busy_play,
    output logic                         done
);
    localparam int CW = `REC_CNT_BITS;
    localparam int LW = `LENGTH_BITS;
    localparam int TW = 16;

    typedef enum logic [2:0] {IDLE, REC, FETCH, HOLD, GAP} state_t;

    state_t                     state_q, state_d;
    logic [CW:0]                rec_count_q, rec_count_d;
    logic [CW-1:0]              play_idx_q, play_idx_d;
    logic [TW-1:0]              tick_cnt_q, tick_cnt_d, tick_nx;
    logic [LW-1:0]              len_q, len_d, hold_len;
    logic [`OCTAVE_BITS-1:0]    play_octave_q, play_octave_d;
    logic [`NOTE_BITS-1:0]      play_note_q, play_note_d;
    logic [`FULL_NOTE_BITS-1:0] play_full_note_q, play_full_note_d;
    logic                       play_valid_q, play_valid_d;
    logic                       done_q, done_d;
    logic                       wr, last, step;

    assign tick_nx  = tick_cnt_q + TW'(1);
    assign hold_len = (len_q == '0) ? LW'(1) : len_q;
    assign last     = play_idx_q == CW'(rec_count_q - (CW+1)'(1));
    // A command in the same cycle as a key press wins, so that key is not stored.
    assign wr       = state_q == REC && key_valid && !rec_count_q[CW] && !stop && !rec_start;

    assign play_valid     = play_valid_q;
    assign play_octave    = play_octave_q;
    assign play_note      = play_note_q;
    assign play_full_note = play_full_note_q;
    assign play_idx       = play_idx_q;
    assign rec_count      = rec_count_q;
    assign full           = rec_count_q[CW];
    assign busy_rec       = state_q == REC;
    assign busy_play      = state_q == FETCH || state_q == HOLD || state_q == GAP;
    assign done           = done_q;

    // Next state: command priority, record counting, tick-timed note/gap durations and song stepping.
    always_comb begin
        state_d          = state_q;
        rec_count_d      = rec_count_q;
        play_idx_d       = play_idx_q;
        tick_cnt_d       = tick_cnt_q;
        len_d            = len_q;
        play_octave_d    = play_octave_q;
        play_note_d      = play_note_q;
        play_full_note_d = play_full_note_q;
        done_d           = 1'b0;
        step             = 1'b0;
        if (stop) begin
            state_d = IDLE;
        end else if (rec_start) begin
            rec_count_d = '0;
            state_d     = REC;
        end else begin
            case (state_q)
                IDLE: begin
                    if (play_start) begin
                        if (rec_count_q == '0) begin
                            done_d = 1'b1;
                        end else begin
                            play_idx_d = '0;
                            state_d    = FETCH;
                        end
                    end
                end
                REC: begin
                    if (wr) rec_count_d = rec_count_q + (CW+1)'(1);
                end
                FETCH: begin
                    len_d            = length_r;
                    play_octave_d    = octave_r;
                    play_note_d      = note_r;
                    play_full_note_d = full_note_r;
                    state_d          = HOLD;
                end
                HOLD: begin
                    if (tick) begin
                        tick_cnt_d = tick_nx;
                        if (tick_nx >= TW'(hold_len)) begin
                            if (GAP_TICKS > 0) state_d = GAP;
                            else step = 1'b1;
                        end
                    end
                end
                GAP: begin
                    if (tick) begin
                        tick_cnt_d = tick_nx;
                        if (tick_nx >= TW'(GAP_TICKS)) step = 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        if (step) begin
            if (!last) begin
                play_idx_d = play_idx_q + CW'(1);
                state_d    = FETCH;
            end else begin
                done_d = 1'b1;
`ifdef REC_LOOP_EN
                play_idx_d = '0;
                state_d    = FETCH;
`else
                state_d    = IDLE;
`endif
            end
        end
        // Ticks seen on the cycle a state is entered belong to the state being left.
        if (state_d != state_q) tick_cnt_d = '0;
        play_valid_d = state_d == HOLD;
    end

    // Memory port: same-cycle write strobe on an accepted key, read strobe for the FETCH cycle.
    always_comb begin
        mem_en        = wr || state_q == FETCH;
        mem_rw        = wr;
        mem_cnt       = wr ? rec_count_q[CW-1:0] : (state_q == FETCH ? play_idx_q : '0);
        mem_octave    = wr ? octave : '0;
        mem_note      = wr ? note : '0;
        mem_length    = wr ? length : '0;
        mem_full_note = wr ? full_note : '0;
    end

    // State and registered outputs; reset abandons any operation at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            rec_count_q      <= '0;
            play_idx_q       <= '0;
            tick_cnt_q       <= '0;
            len_q            <= '0;
            play_octave_q    <= '0;
            play_note_q      <= '0;
            play_full_note_q <= '0;
            play_valid_q     <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q          <= state_d;
            rec_count_q      <= rec_count_d;
            play_idx_q       <= play_idx_d;
            tick_cnt_q       <= tick_cnt_d;
            len_q            <= len_d;
            play_octave_q    <= play_octave_d;
            play_note_q      <= play_note_d;
            play_full_note_q <= play_full_note_d;
            play_valid_q     <= play_valid_d;
            done_q           <= done_d;
        end
    end
endmodule

// File: tb/tb_rec_sequencer.sv
// tb_rec_sequencer: directed and randomized checks of rec_sequencer against a behavioural song model.
`ifndef OCTAVE_BITS
`define OCTAVE_BITS 3
`endif
`ifndef NOTE_BITS
`define NOTE_BITS 4
`endif
`ifndef LENGTH_BITS
`define LENGTH_BITS 3
`endif
`ifndef FULL_NOTE_BITS
`define FULL_NOTE_BITS 2
`endif
`ifndef REC_CNT_BITS
`define REC_CNT_BITS 3
`endif

module tb_rec_sequencer;
    localparam int CW  = `REC_CNT_BITS;
    localparam int SZ  = 1 << CW;
    localparam int OB  = `OCTAVE_BITS;
    localparam int NB  = `NOTE_BITS;
    localparam int LB  = `LENGTH_BITS;
    localparam int FB  = `FULL_NOTE_BITS;
    localparam int GAP = 1;
    localparam int M_IDLE = 0, M_REC = 1, M_FETCH = 2, M_HOLD = 3, M_GAP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rec_start = 1'b0, play_start = 1'b0, stop = 1'b0, tick = 1'b0, key_valid = 1'b0;
    logic [OB-1:0] octave = '0;
    logic [NB-1:0] note = '0;
    logic [LB-1:0] length = '0;
    logic [FB-1:0] full_note = '0;
    logic mem_rw, mem_en, play_valid, full, busy_rec, busy_play, done;
    logic [CW-1:0] mem_cnt, play_idx;
    logic [CW:0] rec_count;
    logic [OB-1:0] mem_octave, octave_r, play_octave;
    logic [NB-1:0] mem_note, note_r, play_note;
    logic [LB-1:0] mem_length, length_r;
    logic [FB-1:0] mem_full_note, full_note_r, play_full_note;

    rec_sequencer #(.GAP_TICKS(GAP)) dut (
        .clk(clk), .rst(rst), .rec_start(rec_start), .play_start(play_start), .stop(stop),
        .tick(tick), .key_valid(key_valid), .octave(octave), .note(note), .length(length),
        .full_note(full_note), .mem_rw(mem_rw), .mem_en(mem_en), .mem_cnt(mem_cnt),
        .mem_octave(mem_octave), .mem_note(mem_note), .mem_length(mem_length),
        .mem_full_note(mem_full_note), .octave_r(octave_r), .note_r(note_r),
        .length_r(length_r), .full_note_r(full_note_r), .play_valid(play_valid),
        .play_octave(play_octave), .play_note(play_note), .play_full_note(play_full_note),
        .play_idx(play_idx), .rec_count(rec_count), .full(full), .busy_rec(busy_rec),
        .busy_play(busy_play), .done(done)
    );

    always #5 clk = ~clk;

    // Record memory fixture: synchronous write, combinational read.
    logic [OB-1:0] fx_oct [SZ];
    logic [NB-1:0] fx_note [SZ];
    logic [LB-1:0] fx_len [SZ];
    logic [FB-1:0] fx_fn [SZ];
    always @(posedge clk) begin
        if (mem_en && mem_rw) begin
            fx_oct[mem_cnt]  <= mem_octave;
            fx_note[mem_cnt] <= mem_note;
            fx_len[mem_cnt]  <= mem_length;
            fx_fn[mem_cnt]   <= mem_full_note;
        end
    end
    assign octave_r    = fx_oct[mem_cnt];
    assign note_r      = fx_note[mem_cnt];
    assign length_r    = fx_len[mem_cnt];
    assign full_note_r = fx_fn[mem_cnt];

    int n_tests = 0, n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the song is an array of notes; durations are remaining-tick countdowns.
    int m_mode, m_cnt, m_idx, m_rem;
    bit m_done;
    int s_oct [SZ], s_note [SZ], s_len [SZ], s_fn [SZ];

    always @(posedge clk or posedge rst) begin
        bit adv;
        adv = 0;
        if (rst) begin
            m_mode = M_IDLE; m_cnt = 0; m_idx = 0; m_rem = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (stop) m_mode = M_IDLE;
            else if (rec_start) begin
                m_cnt = 0; m_mode = M_REC;
            end else if (m_mode == M_IDLE) begin
                if (play_start) begin
                    if (m_cnt == 0) m_done = 1;
                    else begin m_idx = 0; m_mode = M_FETCH; end
                end
            end else if (m_mode == M_REC) begin
                if (key_valid && m_cnt < SZ) begin
                    s_oct[m_cnt] = int'(octave); s_note[m_cnt] = int'(note);
                    s_len[m_cnt] = int'(length); s_fn[m_cnt] = int'(full_note);
                    m_cnt++;
                end
            end else if (m_mode == M_FETCH) begin
                m_rem = (s_len[m_idx] == 0) ? 1 : s_len[m_idx];
                m_mode = M_HOLD;
            end else if (tick) begin
                m_rem--;
                if (m_rem == 0) begin
                    if (m_mode == M_HOLD && GAP > 0) begin m_mode = M_GAP; m_rem = GAP; end
                    else adv = 1;
                end
            end
            if (adv) begin
                if (m_idx == m_cnt - 1) begin
                    m_done = 1;
`ifdef REC_LOOP_EN
                    m_idx = 0; m_mode = M_FETCH;
`else
                    m_mode = M_IDLE;
`endif
                end else begin
                    m_idx++; m_mode = M_FETCH;
                end
            end
        end
    end

    // Compare every cycle, mid-way between active edges.
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            bit wr;
            wr = m_mode == M_REC && key_valid && m_cnt < SZ && !stop && !rec_start;
            chk("mem_en", mem_en, wr || m_mode == M_FETCH);
            chk("mem_rw", mem_rw, wr);
            chk("mem_cnt", mem_cnt, wr ? m_cnt % SZ : (m_mode == M_FETCH ? m_idx : 0));
            chk("mem_octave", mem_octave, wr ? octave : 0);
            chk("mem_note", mem_note, wr ? note : 0);
            chk("mem_length", mem_length, wr ? length : 0);
            chk("mem_full_note", mem_full_note, wr ? full_note : 0);
            chk("busy_rec", busy_rec, m_mode == M_REC);
            chk("busy_play", busy_play, m_mode >= M_FETCH);
            chk("play_valid", play_valid, m_mode == M_HOLD);
            chk("done", done, m_done);
            chk("rec_count", rec_count, m_cnt);
            chk("full", full, m_cnt == SZ);
            chk("play_idx", play_idx, m_idx);
            if (m_mode == M_HOLD) begin
                chk("play_octave", play_octave, s_oct[m_idx]);
                chk("play_note", play_note, s_note[m_idx]);
                chk("play_full_note", play_full_note, s_fn[m_idx]);
            end
        end
    end

    task automatic drive(input bit rs, ps, sp, tk, kv, input int oc, nt, ln, fn);
        @(negedge clk);
        rec_start = rs; play_start = ps; stop = sp; tick = tk; key_valid = kv;
        octave = OB'(oc); note = NB'(nt); length = LB'(ln); full_note = FB'(fn);
    endtask

    task automatic idle(input bit tk);
        drive(0, 0, 0, tk, 0, 0, 0, 0, 0);
    endtask

    int a_oc [3] = '{4, 2, 5};
    int a_nt [3] = '{9, 3, 11};
    int a_ln [3] = '{2, 0, 3};
    int a_fn [3] = '{1, 0, 2};

    initial begin
        logic [12:0] pv_bits, dn_bits;
        #3;
        chk("reset rec_count", rec_count, 0);
        chk("reset mem_en", mem_en, 0);
        chk("reset play_valid", play_valid, 0);
        chk("reset flags", {busy_rec, busy_play, done, full}, 0);
        @(negedge clk);
        rst = 1'b0;
        // Play with an empty song: only a done pulse.
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0); #3;
        chk("empty play mem_en", mem_en, 0);
        idle(0); #3;
        chk("empty play done", done, 1);
        chk("empty play busy_play", busy_play, 0);
        // Record notes A, B, C.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 0, 1, a_oc[i], a_nt[i], a_ln[i], a_fn[i]); #3;
            chk("rec write mem_en", mem_en, 1);
            chk("rec write mem_rw", mem_rw, 1);
            chk("rec write mem_cnt", mem_cnt, i);
            idle(0);
        end
        #3;
        chk("rec_count after 3", rec_count, 3);
        // Play lengths 2,0,3 with a tick every cycle.
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 13; k++) begin
            idle(1); #3;
            pv_bits = {pv_bits[11:0], play_valid};
            dn_bits = {dn_bits[11:0], done};
            if (k == 1) chk("note A pitch", play_note, 9);
            if (k == 5) chk("note B idx", play_idx, 1);
            if (k == 9) chk("note C idx", play_idx, 2);
        end
        chk("play_valid pattern", pv_bits, 13'b0110010011100);
        chk("done pattern", dn_bits, 13'b0000000000001);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
        // stop + rec_start together during HOLD.
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(0); idle(0); #3;
        chk("hold reached", play_valid, 1);
        drive(1, 0, 1, 0, 0, 0, 0, 0, 0);
        idle(0); #3;
        chk("stop+rec play_valid", play_valid, 0);
        chk("stop+rec busy", {busy_rec, busy_play}, 0);
        chk("stop+rec rec_count", rec_count, 3);
        // Asynchronous reset in HOLD.
        drive(0, 1, 0, 0, 0, 0, 0, 0, 0);
        idle(0); idle(0); #3;
        chk("hold before rst", play_valid, 1);
        rst = 1'b1; #1;
        chk("rst play_valid", play_valid, 0);
        chk("rst busy_play", busy_play, 0);
        chk("rst rec_count", rec_count, 0);
        chk("rst mem_en", mem_en, 0);
        @(negedge clk);
        rst = 1'b0;
        // Overfill the memory.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i <= SZ; i++) begin
            drive(0, 0, 0, 0, 1, $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 3)); #3;
            if (i == SZ) begin
                chk("full no write", mem_en, 0);
                chk("full flag", full, 1);
            end
        end
        idle(0); #3;
        chk("rec_count saturates", rec_count, SZ);
        // Two-note song: end-of-song behaviour.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 1, 1, 1, 1);
        drive(0, 0, 0, 0, 1, 2, 2, 1, 2);
        drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
        drive(0, 1, 0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 7; k++) idle(1);
        #3;
        chk("two-note done", done, 1);
`ifdef REC_LOOP_EN
        chk("two-note wrap busy", busy_play, 1);
        chk("two-note wrap idx", play_idx, 0);
`else
        chk("two-note end busy", busy_play, 0);
        chk("two-note end idx", play_idx, 1);
`endif
        // Randomized rounds: record, then play with random ticks and stray commands.
        for (int r = 0; r < 30; r++) begin
            automatic int n = $urandom_range(4, 30);
            drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
            for (int c = 0; c < n; c++)
                drive(0, 0, 0, $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 7),
                      $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 3));
            drive(0, 0, 1, 0, 0, 0, 0, 0, 0);
            n = $urandom_range(20, 300);
            for (int c = 0; c < n; c++)
                drive($urandom_range(0, 299) == 0, c == 0 || $urandom_range(0, 49) == 0,
                      $urandom_range(0, 249) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                      $urandom_range(0, 7), $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 3));
        end
        idle(0);
        #3;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
